// File: rtl/fpu_pkg.sv
// Shared FPU front-end definitions: word widths, opcodes, the quiet-NaN
// error result, the operand bundle driven to the FPU and an opcode helper.
package fpu_pkg;

  localparam int unsigned FP_W = 32;
  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_MUL = 3'b010;
  localparam logic [OP_W-1:0] OP_DIV = 3'b011;

  // Result returned for ops that never reach the FPU datapath.
  localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

  // Operand bundle held on the FPU input ports.
  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [FP_W-1:0] a;
    logic [FP_W-1:0] b;
  } fpu_operands_t;

  // Opcodes with the top bit set are reserved.
  function automatic logic is_reserved_op(input logic [OP_W-1:0] op);
    return op[OP_W-1];
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Client-side request/response bundle of the FPU issue controller.
//   request : ReqValid/ReqReady handshake carrying ReqOp, ReqA, ReqB, ReqTag
//   response: RspValid/RspReady handshake carrying RspResult, RspTag, RspErr
// master = client side, slave = issue controller side.
interface fpu_issue_ctrl_if import fpu_pkg::*; #(
  parameter int unsigned TAG_W = 4
);

  logic             ReqValid;
  logic             ReqReady;
  logic [OP_W-1:0]  ReqOp;
  logic [FP_W-1:0]  ReqA;
  logic [FP_W-1:0]  ReqB;
  logic [TAG_W-1:0] ReqTag;

  logic             RspValid;
  logic             RspReady;
  logic [FP_W-1:0]  RspResult;
  logic [TAG_W-1:0] RspTag;
  logic             RspErr;

  modport master (
    output ReqValid, ReqOp, ReqA, ReqB, ReqTag, RspReady,
    input  ReqReady, RspValid, RspResult, RspTag, RspErr
  );

  modport slave (
    input  ReqValid, ReqOp, ReqA, ReqB, ReqTag, RspReady,
    output ReqReady, RspValid, RspResult, RspTag, RspErr
  );

endinterface

// File: rtl/fpu_rsp_fifo.sv
// In-order response FIFO. Simultaneous push and pop are allowed in every
// state, including full. The head word is presented on pop_data whenever
// empty is low.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push, push_data   write request and word
//   pop               remove the head word
//   pop_data          head word
//   full, empty       occupancy flags
module fpu_rsp_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; only words between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue controller in front of a fixed-latency FPU core. Accepts tagged ops
// over a valid/ready handshake, drives the FPU operand ports, follows each op
// through the FPU latency and returns results in order with their tags.
// Ports:
//   CLK, RST             clock, asynchronous active-high reset
//   client               request/response bundle (slave side)
//   Operand1, Operand2   operands to the FPU
//   Operation            opcode to the FPU
//   Result               FPU result, valid FPU_LATENCY edges after operands
module fpu_issue_ctrl import fpu_pkg::*; #(
  parameter int unsigned FPU_LATENCY = 2,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TAG_W       = 4
) (
  input  logic             CLK,
  input  logic             RST,
  fpu_issue_ctrl_if.slave  client,
  output logic [FP_W-1:0]  Operand1,
  output logic [FP_W-1:0]  Operand2,
  output logic [OP_W-1:0]  Operation,
  input  logic [FP_W-1:0]  Result
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W = FP_W + 1 + TAG_W;

  typedef struct packed {
    logic             valid;
    logic             err;
    logic [TAG_W-1:0] tag;
  } pipe_ent_t;

  logic [CNT_W-1:0] credits;
  logic             accept;
  logic             pop;
  logic             req_err;
  fpu_operands_t    operands;
  pipe_ent_t        pipe [FPU_LATENCY];
  pipe_ent_t        pipe_tail;
  logic             push;
  logic [ENT_W-1:0] push_data;
  logic [ENT_W-1:0] head_data;
  logic             fifo_empty;
  logic             fifo_full_unused;

  // Credits count free slots across the pipe and the FIFO together.
  assign client.ReqReady = (credits != '0) && !RST;
  assign accept          = client.ReqValid && client.ReqReady;
  assign req_err         = is_reserved_op(client.ReqOp);
  assign pop             = client.RspValid && client.RspReady;

  // Credit counter: take one per accept, return one per response pop.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      credits <= CNT_W'(DEPTH);
    end else begin
      case ({accept, pop})
        2'b10:   credits <= credits - CNT_W'(1);
        2'b01:   credits <= credits + CNT_W'(1);
        default: credits <= credits;
      endcase
    end
  end

  // FPU operand registers; reserved ops leave the ports untouched.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      operands <= '0;
    end else if (accept && !req_err) begin
      operands <= '{op: client.ReqOp, a: client.ReqA, b: client.ReqB};
    end
  end

  assign Operand1  = operands.a;
  assign Operand2  = operands.b;
  assign Operation = operands.op;

  // Tracking pipe: one stage per FPU latency edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < int'(FPU_LATENCY); i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{valid: accept, err: req_err, tag: client.ReqTag};
      for (int i = 1; i < int'(FPU_LATENCY); i++) pipe[i] <= pipe[i-1];
    end
  end

  // The tail entry lines up with the edge at which Result is valid.
  assign pipe_tail = pipe[FPU_LATENCY-1];
  assign push      = pipe_tail.valid;
  assign push_data = {(pipe_tail.err ? FP_QNAN : Result), pipe_tail.err, pipe_tail.tag};

  // Credits make a push into a full FIFO impossible, so full goes unused.
  fpu_rsp_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head_data),
    .full      (fifo_full_unused),
    .empty     (fifo_empty)
  );

  assign client.RspValid = !fifo_empty;
  assign {client.RspResult, client.RspErr, client.RspTag} = head_data;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl. The FPU core is replaced by a two-cycle stand-in
// whose arithmetic is integer add/sub/xor/or, plus one real single-precision
// add vector, so expected results can be worked out by hand.
module tb_fpu_issue_ctrl;
  import fpu_pkg::*;

  localparam int unsigned FPU_LATENCY = 2;
  localparam int unsigned DEPTH       = 4;
  localparam int unsigned TAG_W       = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] Operand1;
  logic [31:0] Operand2;
  logic [2:0]  Operation;
  logic [31:0] Result;
  logic [31:0] fpu_q = '0;

  fpu_issue_ctrl_if #(.TAG_W(TAG_W)) client ();

  fpu_issue_ctrl #(
    .FPU_LATENCY (FPU_LATENCY),
    .DEPTH       (DEPTH),
    .TAG_W       (TAG_W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .client    (client),
    .Operand1  (Operand1),
    .Operand2  (Operand2),
    .Operation (Operation),
    .Result    (Result)
  );

  always #5 CLK = ~CLK;

  // Stand-in FPU datapath.
  function automatic logic [31:0] fpu_func(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    if (op == 3'b000 && a == 32'h46BF_CA0A && b == 32'h424B_EB85) return 32'h46C0_3000;
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a ^ b;
      3'b011:  return a | b;
      default: return 32'hBAD0_BAD0;
    endcase
  endfunction

  // Two edges from operands to a sampled Result.
  always @(posedge CLK) fpu_q <= fpu_func(Operation, Operand1, Operand2);
  assign Result = fpu_q;

  typedef struct packed {
    logic [2:0]       op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
  } acc_t;

  typedef struct packed {
    logic [31:0]      result;
    logic             err;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  typedef struct {
    logic [2:0]       op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp_result;
    logic             exp_err;
  } vec_t;

  acc_t acc_q[$];
  rsp_t rsp_q[$];
  int   rsp_cyc_q[$];
  int   cyc = 0;

  // Handshake monitor; values at the falling edge are those seen by the next rising edge.
  always @(negedge CLK) begin
    if (!RST) begin
      if (client.ReqValid && client.ReqReady)
        acc_q.push_back('{op: client.ReqOp, a: client.ReqA, b: client.ReqB, tag: client.ReqTag});
      if (client.RspValid && client.RspReady) begin
        rsp_q.push_back('{result: client.RspResult, err: client.RspErr, tag: client.RspTag});
        rsp_cyc_q.push_back(cyc);
      end
    end
    cyc++;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [TAG_W-1:0] tag);
    client.ReqValid = v;
    client.ReqOp    = op;
    client.ReqA     = a;
    client.ReqB     = b;
    client.ReqTag   = tag;
  endtask

  vec_t        vecs [6];
  rsp_t        exp_r;
  acc_t        acc;
  logic [31:0] last_a, last_b;
  logic [2:0]  last_op, rop;
  int          base_r, base_a, n_acc, cycles, n_new;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{3'b000, 32'h0000_1000, 32'h0000_0234, 4'd0, 32'h0000_1234, 1'b0};
    vecs[1] = '{3'b001, 32'h0000_5000, 32'h0000_0001, 4'd1, 32'h0000_4FFF, 1'b0};
    vecs[2] = '{3'b010, 32'hF0F0_0000, 32'h0F0F_0000, 4'd2, 32'hFFFF_0000, 1'b0};
    vecs[3] = '{3'b011, 32'h1200_0000, 32'h0034_0000, 4'd3, 32'h1234_0000, 1'b0};
    vecs[4] = '{3'b101, 32'hDEAD_BEEF, 32'hCAFE_F00D, 4'd9, 32'h7FC0_0000, 1'b1};
    vecs[5] = '{3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 4'd4, 32'h0000_0001, 1'b0};

    drive(1'b0, 3'b000, '0, '0, '0);
    client.RspReady = 1'b0;
    RST = 1'b1;
    repeat (3) tick();

    // Reset state.
    check("rst_req_ready", 64'(client.ReqReady), 64'd0);
    check("rst_rsp_valid", 64'(client.RspValid), 64'd0);
    check("rst_operands", {Operand1, Operand2}, 64'd0);
    check("rst_operation", 64'(Operation), 64'd0);
    RST = 1'b0;
    tick();
    check("req_ready_after_rst", 64'(client.ReqReady), 64'd1);

    // Single add with exact latency.
    client.RspReady = 1'b1;
    drive(1'b1, OP_ADD, 32'h46BF_CA0A, 32'h424B_EB85, 4'd5);
    tick();
    client.ReqValid = 1'b0;
    check("add_operands", {Operand1, Operand2}, {32'h46BF_CA0A, 32'h424B_EB85});
    check("add_operation", 64'(Operation), 64'd0);
    check("add_rsp_valid_k", 64'(client.RspValid), 64'd0);
    tick();
    check("add_rsp_valid_k1", 64'(client.RspValid), 64'd0);
    tick();
    check("add_rsp_valid_k2", 64'(client.RspValid), 64'd1);
    check("add_rsp", 64'({client.RspResult, client.RspErr, client.RspTag}),
          64'({32'h46C0_3000, 1'b0, 4'd5}));
    tick();
    check("add_rsp_popped", 64'(client.RspValid), 64'd0);

    // Back-to-back table, including a reserved opcode mid-stream.
    base_r  = rsp_q.size();
    last_a  = 32'h46BF_CA0A;
    last_b  = 32'h424B_EB85;
    last_op = 3'b000;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      check("b2b_req_ready", 64'(client.ReqReady), 64'd1);
      tick();
      if (!vecs[i].op[2]) begin
        last_a  = vecs[i].a;
        last_b  = vecs[i].b;
        last_op = vecs[i].op;
      end
      check("b2b_fpu_ports", {Operand1, Operand2}, {last_a, last_b});
      check("b2b_fpu_op", 64'(Operation), 64'(last_op));
    end
    client.ReqValid = 1'b0;
    repeat (6) tick();
    check("b2b_rsp_count", 64'(rsp_q.size() - base_r), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (base_r + i < rsp_q.size()) begin
        check("b2b_rsp", 64'(rsp_q[base_r+i]),
              64'({vecs[i].exp_result, vecs[i].exp_err, vecs[i].tag}));
        if (i > 0)
          check("b2b_consecutive", 64'(rsp_cyc_q[base_r+i] - rsp_cyc_q[base_r+i-1]), 64'd1);
      end
    end

    // Backpressure: only DEPTH ops fit.
    client.RspReady = 1'b0;
    base_r = rsp_q.size();
    n_acc  = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, OP_ADD, 32'(i), 32'h100, TAG_W'(i));
      if (client.ReqReady) n_acc++;
      tick();
    end
    client.ReqValid = 1'b0;
    check("bp_accepts", 64'(n_acc), 64'd4);
    check("bp_req_ready_low", 64'(client.ReqReady), 64'd0);
    check("bp_head", 64'({client.RspValid, client.RspResult, client.RspTag}),
          64'({1'b1, 32'h100, 4'd0}));
    tick();
    check("bp_head_held", 64'({client.RspValid, client.RspResult, client.RspTag}),
          64'({1'b1, 32'h100, 4'd0}));
    client.RspReady = 1'b1;
    tick();
    client.RspReady = 1'b0;
    check("bp_credit_back", 64'(client.ReqReady), 64'd1);
    check("bp_next_head", 64'(client.RspTag), 64'd1);
    n_acc = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, OP_SUB, 32'h50, 32'(i), TAG_W'(10 + i));
      if (client.ReqReady) n_acc++;
      tick();
    end
    client.ReqValid = 1'b0;
    check("bp_one_more", 64'(n_acc), 64'd1);
    check("bp_req_ready_low2", 64'(client.ReqReady), 64'd0);
    client.RspReady = 1'b1;
    repeat (10) tick();
    check("bp_rsp_count", 64'(rsp_q.size() - base_r), 64'd5);
    for (int i = 0; i < 5; i++) begin
      exp_r = (i < 4) ? '{32'h100 + 32'(i), 1'b0, TAG_W'(i)} : '{32'h50, 1'b0, 4'd10};
      if (base_r + i < rsp_q.size()) check("bp_rsp", 64'(rsp_q[base_r+i]), 64'(exp_r));
    end

    // Reset with ops in flight.
    client.RspReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, OP_MUL, 32'h11 * 32'(i + 1), 32'h1, TAG_W'(12 + i));
      tick();
    end
    client.ReqValid = 1'b0;
    RST = 1'b1;
    #1;
    check("mid_rst_rsp_valid", 64'(client.RspValid), 64'd0);
    check("mid_rst_operands", {Operand1, Operand2}, 64'd0);
    check("mid_rst_operation", 64'(Operation), 64'd0);
    check("mid_rst_req_ready", 64'(client.ReqReady), 64'd0);
    tick();
    RST = 1'b0;
    base_r = rsp_q.size();
    client.RspReady = 1'b1;
    repeat (8) tick();
    check("mid_rst_no_stale", 64'(rsp_q.size() - base_r), 64'd0);
    check("mid_rst_rsp_valid2", 64'(client.RspValid), 64'd0);
    client.RspReady = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, OP_DIV, 32'(i) << 4, 32'h1, TAG_W'(i));
      if (client.ReqReady) n_acc++;
      tick();
    end
    client.ReqValid = 1'b0;
    check("mid_rst_accepts", 64'(n_acc), 64'd4);
    client.RspReady = 1'b1;
    repeat (10) tick();
    check("mid_rst_rsp_count", 64'(rsp_q.size() - base_r), 64'd4);
    for (int i = 0; i < 4; i++) begin
      exp_r = '{(32'(i) << 4) | 32'h1, 1'b0, TAG_W'(i)};
      if (base_r + i < rsp_q.size()) check("mid_rst_rsp", 64'(rsp_q[base_r+i]), 64'(exp_r));
    end

    // Random traffic with RspReady toggling every cycle, against a scoreboard.
    base_a = acc_q.size();
    base_r = rsp_q.size();
    cycles = 0;
    client.RspReady = 1'b0;
    while ((acc_q.size() - base_a) < 100 && cycles < 2000) begin
      client.RspReady = ~client.RspReady;
      if ($urandom_range(0, 3) == 0) rop = 3'b100 | 3'($urandom_range(0, 3));
      else                           rop = 3'($urandom_range(0, 3));
      drive(($urandom_range(0, 9) != 0), rop, $urandom, $urandom, TAG_W'($urandom_range(0, 15)));
      tick();
      cycles++;
    end
    client.ReqValid = 1'b0;
    check("rand_accepts", 64'(acc_q.size() - base_a), 64'd100);
    client.RspReady = 1'b1;
    cycles = 0;
    while ((rsp_q.size() - base_r) < (acc_q.size() - base_a) && cycles < 60) begin
      tick();
      cycles++;
    end
    repeat (4) tick();
    n_new = acc_q.size() - base_a;
    check("rand_rsp_count", 64'(rsp_q.size() - base_r), 64'(n_new));
    for (int i = 0; i < n_new; i++) begin
      acc   = acc_q[base_a+i];
      exp_r = '{acc.op[2] ? 32'h7FC0_0000 : fpu_func(acc.op, acc.a, acc.b), acc.op[2], acc.tag};
      if (base_r + i < rsp_q.size()) check("rand_rsp", 64'(rsp_q[base_r+i]), 64'(exp_r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
